// File: rtl/serialize_hybrid.sv
// Turns an 8-element vector into 4 two-lane beats for a 2-lane hybrid reducer.
// Beat k carries elements 2k and 2k+1. A load on the LAST beat starts the next vector with no gap.
//
// state | meaning
// IDLE  | buffer empty, READY=1, outputs zero
// SEND  | presenting beat beat_q from the holding buffer
module serialize_hybrid #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I_0,
    input  logic [WIDTH-1:0] I_1,
    input  logic [WIDTH-1:0] I_2,
    input  logic [WIDTH-1:0] I_3,
    input  logic [WIDTH-1:0] I_4,
    input  logic [WIDTH-1:0] I_5,
    input  logic [WIDTH-1:0] I_6,
    input  logic [WIDTH-1:0] I_7,
    input  logic             WE,
    output logic             READY,
    input  logic             EN,
    output logic [WIDTH-1:0] O_0,
    output logic [WIDTH-1:0] O_1,
    output logic             V,
    output logic             FIRST,
    output logic             LAST
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [WIDTH-1:0] buf_q [8];
    logic [WIDTH-1:0] buf_d [8];
    logic [WIDTH-1:0] din   [8];
    logic             accept;

    assign din[0] = I_0;
    assign din[1] = I_1;
    assign din[2] = I_2;
    assign din[3] = I_3;
    assign din[4] = I_4;
    assign din[5] = I_5;
    assign din[6] = I_6;
    assign din[7] = I_7;

    // Outputs depend only on registers, except READY which also looks at EN.
    always_comb begin
        READY = 1'b0;
        V     = 1'b0;
        FIRST = 1'b0;
        LAST  = 1'b0;
        O_0   = '0;
        O_1   = '0;
        if (state_q == IDLE) begin
            READY = 1'b1;
        end else begin
            V     = 1'b1;
            O_0   = buf_q[{beat_q, 1'b0}];
            O_1   = buf_q[{beat_q, 1'b1}];
            FIRST = (beat_q == 2'd0);
            LAST  = (beat_q == 2'd3);
            READY = (beat_q == 2'd3) && EN;
        end
    end

    assign accept = WE & READY;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        for (int i = 0; i < 8; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                buf_d[i] = din[i];
            end
            state_d = SEND;
            beat_d  = 2'd0;
        end else if (state_q == SEND && EN) begin
            if (beat_q == 2'd3) begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_serialize_hybrid.sv
// Directed bench for serialize_hybrid: inputs change and outputs are sampled on the falling edge.
module tb_serialize_hybrid;

    logic        CLK;
    logic        ASYNCRESETN;
    logic [15:0] din [8];
    logic        WE;
    logic        READY;
    logic        EN;
    logic [15:0] O_0;
    logic [15:0] O_1;
    logic        V;
    logic        FIRST;
    logic        LAST;

    int checks;
    int errors;

    serialize_hybrid #(.WIDTH(16)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I_0        (din[0]),
        .I_1        (din[1]),
        .I_2        (din[2]),
        .I_3        (din[3]),
        .I_4        (din[4]),
        .I_5        (din[5]),
        .I_6        (din[6]),
        .I_7        (din[7]),
        .WE         (WE),
        .READY      (READY),
        .EN         (EN),
        .O_0        (O_0),
        .O_1        (O_1),
        .V          (V),
        .FIRST      (FIRST),
        .LAST       (LAST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic set_vec(input int base, input int step);
        for (int i = 0; i < 8; i++) begin
            din[i] = 16'(base + i * step);
        end
    endtask

    task automatic test_reset();
        ASYNCRESETN = 1'b0;
        WE = 1'b0;
        EN = 1'b1;
        set_vec(0, 0);
        #1;
        checks++;
        if (V !== 1'b0 || READY !== 1'b1 || FIRST !== 1'b0 || LAST !== 1'b0 ||
            O_0 !== 16'h0 || O_1 !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: V=%b READY=%b FIRST=%b LAST=%b O_0=%h O_1=%h, need 0 1 0 0 0000 0000",
                     V, READY, FIRST, LAST, O_0, O_1);
        end
        @(negedge CLK);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if (V !== 1'b0 || READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_after_release: V=%b READY=%b, need 0 1", V, READY);
        end
    endtask

    task automatic test_basic();
        set_vec(1, 1);
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (V !== 1'b1 || O_0 !== 16'(2*k+1) || O_1 !== 16'(2*k+2) ||
                FIRST !== (k == 0) || LAST !== (k == 3) || READY !== (k == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d: V=%b O=(%0d,%0d) F=%b L=%b R=%b, need 1 (%0d,%0d) F=%b L=%b R=%b",
                         k, V, O_0, O_1, FIRST, LAST, READY, 2*k+1, 2*k+2, k == 0, k == 3, k == 3);
            end
            @(negedge CLK);
        end
        checks++;
        if (V !== 1'b0 || READY !== 1'b1 || O_0 !== 16'h0 || O_1 !== 16'h0) begin
            errors++;
            $display("FAIL basic_end_idle: V=%b READY=%b O=(%h,%h), need 0 1 (0000,0000)", V, READY, O_0, O_1);
        end
    endtask

    task automatic test_stall();
        set_vec(1, 1);
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        @(negedge CLK);
        EN = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) EN = 1'b1;
            #1;
            checks++;
            if (V !== 1'b1 || O_0 !== 16'd3 || O_1 !== 16'd4 || READY !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: V=%b O=(%0d,%0d) READY=%b, need 1 (3,4) 0", c, V, O_0, O_1, READY);
            end
            @(negedge CLK);
        end
        for (int k = 2; k < 4; k++) begin
            checks++;
            if (V !== 1'b1 || O_0 !== 16'(2*k+1) || O_1 !== 16'(2*k+2) || LAST !== (k == 3)) begin
                errors++;
                $display("FAIL stall_resume%0d: V=%b O=(%0d,%0d) L=%b, need 1 (%0d,%0d) L=%b",
                         k, V, O_0, O_1, LAST, 2*k+1, 2*k+2, k == 3);
            end
            @(negedge CLK);
        end
        checks++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL stall_end_idle: V=%b, need 0", V);
        end
    endtask

    task automatic test_back_to_back();
        set_vec(10, 1);
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        for (int n = 0; n < 8; n++) begin
            int vbase;
            int k;
            vbase = (n < 4) ? 10 : 20;
            k = n % 4;
            checks++;
            if (V !== 1'b1 || O_0 !== 16'(vbase + 2*k) || O_1 !== 16'(vbase + 2*k + 1) ||
                FIRST !== (k == 0) || LAST !== (k == 3)) begin
                errors++;
                $display("FAIL b2b_beat%0d: V=%b O=(%0d,%0d) F=%b L=%b, need 1 (%0d,%0d) F=%b L=%b",
                         n, V, O_0, O_1, FIRST, LAST, vbase + 2*k, vbase + 2*k + 1, k == 0, k == 3);
            end
            if (n == 3) begin
                set_vec(20, 1);
                WE = 1'b1;
                #1;
                checks++;
                if (READY !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_on_last: READY=%b, need 1", READY);
                end
            end
            @(negedge CLK);
            WE = 1'b0;
        end
        checks++;
        if (V !== 1'b0 || READY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end_idle: V=%b READY=%b, need 0 1", V, READY);
        end
    endtask

    task automatic test_ignored_load();
        set_vec(1, 1);
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        @(negedge CLK);
        set_vec(16'hFFFF, 0);
        WE = 1'b1;
        #1;
        checks++;
        if (READY !== 1'b0 || O_0 !== 16'd3 || O_1 !== 16'd4) begin
            errors++;
            $display("FAIL ignored_beat1: READY=%b O=(%0d,%0d), need 0 (3,4)", READY, O_0, O_1);
        end
        @(negedge CLK);
        WE = 1'b0;
        for (int k = 2; k < 4; k++) begin
            checks++;
            if (V !== 1'b1 || O_0 !== 16'(2*k+1) || O_1 !== 16'(2*k+2)) begin
                errors++;
                $display("FAIL ignored_beat%0d: V=%b O=(%h,%h), need 1 (%h,%h)",
                         k, V, O_0, O_1, 16'(2*k+1), 16'(2*k+2));
            end
            @(negedge CLK);
        end
        checks++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL ignored_end_idle: V=%b, need 0", V);
        end
    endtask

    task automatic test_reset_mid();
        set_vec(1, 1);
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (O_0 !== 16'd5 || O_1 !== 16'd6) begin
            errors++;
            $display("FAIL rstmid_beat2: O=(%0d,%0d), need (5,6)", O_0, O_1);
        end
        #1;
        ASYNCRESETN = 1'b0;
        #1;
        checks++;
        if (V !== 1'b0 || O_0 !== 16'h0 || O_1 !== 16'h0 || READY !== 1'b1 || FIRST !== 1'b0 || LAST !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: V=%b O=(%h,%h) READY=%b F=%b L=%b, need 0 (0000,0000) 1 0 0",
                     V, O_0, O_1, READY, FIRST, LAST);
        end
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if (V !== 1'b0 || O_0 !== 16'h0 || O_1 !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_no_resume: V=%b O=(%0d,%0d), need 0 (0,0)", V, O_0, O_1);
        end
        set_vec(40, 1);
        WE = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        checks++;
        if (V !== 1'b1 || O_0 !== 16'd40 || O_1 !== 16'd41 || FIRST !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reload: V=%b O=(%0d,%0d) F=%b, need 1 (40,41) 1", V, O_0, O_1, FIRST);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_end_to_end();
        logic [15:0] acc;
        int beats;
        acc = 16'h0;
        beats = 0;
        set_vec(0, 0);
        din[0] = 16'hFFFF;
        din[1] = 16'h0001;
        WE = 1'b1;
        EN = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (V && EN) begin
                acc = FIRST ? (O_0 + O_1) : (acc + O_0 + O_1);
                beats++;
            end
            @(negedge CLK);
        end
        checks++;
        if (acc !== 16'h0000 || beats != 4) begin
            errors++;
            $display("FAIL e2e_reduce: acc=%h beats=%0d, need 0000 4", acc, beats);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid();
        test_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
